// File: rtl/johnson_4_decoder.sv
// Johnson-code receive decoder and sequence monitor with HUNT/ACQ/LOCK tracking.
// Optional macro JOHNSON_DEC_ERRCNT_EN implements the saturating err_cnt register; otherwise err_cnt is 0.
module johnson_4_decoder #(
  parameter int N        = 4,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N-1:0]                q,
  output logic [$clog2(2*N)-1:0]      idx,
  output logic                        valid,
  output logic                        illegal,
  output logic                        seq_err,
  output logic                        locked,
  output logic [ERR_W-1:0]            err_cnt
);

  // state | meaning
  // HUNT  | no reference index; waiting for any legal code
  // ACQ   | reference captured; counting correct successors toward lock
  // LOCK  | sequence tracked; any break is reported as seq_err
  typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

  localparam int IW = $clog2(2*N);
  localparam int RW = $clog2(LOCK_LEN + 1);

  state_t          state;
  logic [RW-1:0]   run;
  logic [N-2:0]    diff;
  logic            legal;
  logic [IW-1:0]   pc;
  logic [IW-1:0]   dec_idx;
  logic [IW-1:0]   succ;
  logic            succ_ok;

  always_comb begin
    diff  = q[N-1:1] ^ q[N-2:0];
    legal = ((diff & (diff - 1'b1)) == '0);
    pc    = '0;
    for (int i = 0; i < N; i++) pc = pc + IW'(q[i]);
    // Upper half of the cycle counts down from 2N as ones shift out.
    dec_idx = q[N-1] ? IW'(2*N - int'(pc)) : pc;
    succ    = (idx == IW'(2*N - 1)) ? '0 : idx + 1'b1;
    succ_ok = legal && (dec_idx == succ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      run     <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      locked  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      if (en) begin
        if (legal) begin
          valid <= 1'b1;
          idx   <= dec_idx;
        end
        case (state)
          HUNT: begin
            if (legal) begin
              state <= ACQ;
              run   <= '0;
            end else begin
              illegal <= 1'b1;
            end
          end
          ACQ: begin
            if (!legal) begin
              illegal <= 1'b1;
              state   <= HUNT;
            end else if (succ_ok) begin
              if (run == RW'(LOCK_LEN - 1)) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                run <= run + 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCK: begin
            if (!legal) begin
              illegal <= 1'b1;
              seq_err <= 1'b1;
              locked  <= 1'b0;
              state   <= HUNT;
            end else if (!succ_ok) begin
              seq_err <= 1'b1;
              locked  <= 1'b0;
              run     <= '0;
              state   <= ACQ;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic err_evt;
  assign err_evt = en && (state == LOCK) && !succ_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_4_decoder.sv
// Self-checking bench for johnson_4_decoder: directed vector table, hand sequences, random vs reference model.
module tb_johnson_4_decoder;

  localparam int N   = 4;
  localparam int LL  = 2;
  localparam int EW  = 2;
  localparam int IW  = 3;
  localparam int M   = 2*N;
`ifdef JOHNSON_DEC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en;
  logic [N-1:0]  q;
  logic [IW-1:0] idx;
  logic          valid, illegal, seq_err, locked;
  logic [EW-1:0] err_cnt;

  johnson_4_decoder #(.N(N), .LOCK_LEN(LL), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .en(en), .q(q), .idx(idx), .valid(valid),
    .illegal(illegal), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: code table built by shifting, plus lock bookkeeping.
  logic [N-1:0] jt [M];
  int m_mode, m_run, m_idx, m_err;
  logic e_valid, e_illegal, e_seq;

  function automatic int lookup(input logic [N-1:0] c);
    for (int k = 0; k < M; k++) if (jt[k] == c) return k;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] c);
    int k;
    bit ok;
    e_valid = 0; e_illegal = 0; e_seq = 0;
    if (r) begin
      m_mode = 0; m_run = 0; m_idx = 0; m_err = 0;
    end else if (e) begin
      k  = lookup(c);
      ok = (k >= 0) && (k == (m_idx + 1) % M);
      if (k >= 0) e_valid = 1;
      case (m_mode)
        0: if (k >= 0) begin m_mode = 1; m_run = 0; end else e_illegal = 1;
        1: if (k < 0) begin e_illegal = 1; m_mode = 0; end
           else if (ok) begin m_run++; if (m_run == LL) m_mode = 2; end
           else m_run = 0;
        default: if (k < 0) begin
                   e_illegal = 1; e_seq = 1; m_mode = 0;
                   if (m_err < (1 << EW) - 1) m_err++;
                 end else if (!ok) begin
                   e_seq = 1; m_mode = 1; m_run = 0;
                   if (m_err < (1 << EW) - 1) m_err++;
                 end
      endcase
      if (k >= 0) m_idx = k;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] c);
    @(negedge clk);
    rst = r; en = e; q = c;
    @(posedge clk);
    model_step(r, e, c);
    #1;
  endtask

  task automatic check(input string nm, input int ei, input bit ev, input bit eil,
                       input bit es, input bit el, input int ee);
    int ee_g;
    ee_g = ERRCNT ? ee : 0;
    n_vec++;
    if (idx !== IW'(ei)) begin n_err++; $display("FAIL %s idx got %0d want %0d", nm, idx, ei); end
    if (valid !== ev) begin n_err++; $display("FAIL %s valid got %0b want %0b", nm, valid, ev); end
    if (illegal !== eil) begin n_err++; $display("FAIL %s illegal got %0b want %0b", nm, illegal, eil); end
    if (seq_err !== es) begin n_err++; $display("FAIL %s seq_err got %0b want %0b", nm, seq_err, es); end
    if (locked !== el) begin n_err++; $display("FAIL %s locked got %0b want %0b", nm, locked, el); end
    if (err_cnt !== EW'(ee_g)) begin n_err++; $display("FAIL %s err_cnt got %0d want %0d", nm, err_cnt, ee_g); end
  endtask

  typedef struct {
    logic r; logic e; logic [N-1:0] c;
    int i; bit v; bit il; bit s; bit l; int ec;
  } vec_t;

  vec_t tv [25];

  initial begin
    jt[0] = '0;
    for (int k = 1; k < M; k++) jt[k] = {jt[k-1][N-2:0], ~jt[k-1][N-1]};

    //          r  e  q        idx v il s l err
    tv[0]  = '{1, 1, 4'b0000, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 4'b0000, 0, 1, 0, 0, 0, 0};
    tv[2]  = '{0, 1, 4'b0001, 1, 1, 0, 0, 0, 0};
    tv[3]  = '{0, 1, 4'b0011, 2, 1, 0, 0, 1, 0};
    tv[4]  = '{0, 1, 4'b0111, 3, 1, 0, 0, 1, 0};
    tv[5]  = '{0, 1, 4'b1111, 4, 1, 0, 0, 1, 0};
    tv[6]  = '{0, 1, 4'b1110, 5, 1, 0, 0, 1, 0};
    tv[7]  = '{0, 1, 4'b1100, 6, 1, 0, 0, 1, 0};
    tv[8]  = '{0, 1, 4'b1000, 7, 1, 0, 0, 1, 0};
    tv[9]  = '{0, 1, 4'b0000, 0, 1, 0, 0, 1, 0};
    tv[10] = '{0, 1, 4'b0001, 1, 1, 0, 0, 1, 0};
    tv[11] = '{0, 1, 4'b0011, 2, 1, 0, 0, 1, 0};
    tv[12] = '{0, 1, 4'b0101, 2, 0, 1, 1, 0, 1};
    tv[13] = '{0, 1, 4'b0011, 2, 1, 0, 0, 0, 1};
    tv[14] = '{0, 1, 4'b0111, 3, 1, 0, 0, 0, 1};
    tv[15] = '{0, 1, 4'b1111, 4, 1, 0, 0, 1, 1};
    tv[16] = '{0, 1, 4'b1100, 6, 1, 0, 1, 0, 2};
    tv[17] = '{0, 1, 4'b1000, 7, 1, 0, 0, 0, 2};
    tv[18] = '{0, 1, 4'b0000, 0, 1, 0, 0, 1, 2};
    tv[19] = '{0, 0, 4'b0101, 0, 0, 0, 0, 1, 2};
    tv[20] = '{0, 0, 4'b0101, 0, 0, 0, 0, 1, 2};
    tv[21] = '{0, 0, 4'b0101, 0, 0, 0, 0, 1, 2};
    tv[22] = '{0, 1, 4'b0001, 1, 1, 0, 0, 1, 2};
    tv[23] = '{0, 1, 4'b0001, 1, 1, 0, 1, 0, 3};
    tv[24] = '{1, 1, 4'b0011, 0, 0, 0, 0, 0, 0};

    rst = 1; en = 0; q = '0;
    m_mode = 0; m_run = 0; m_idx = 0; m_err = 0;

    for (int t = 0; t < 25; t++) begin
      step(tv[t].r, tv[t].e, tv[t].c);
      check($sformatf("tbl%0d", t), tv[t].i, tv[t].v, tv[t].il, tv[t].s, tv[t].l, tv[t].ec);
    end

    // Five breaks with relock in between: counter saturates at 3.
    begin
      int sat_exp [5];
      sat_exp = '{1, 2, 3, 3, 3};
      step(1, 0, 4'b0000);
      for (int b = 0; b < 5; b++) begin
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0011);
        check($sformatf("relock%0d", b), 2, 1, 0, 0, 1, (b == 0) ? 0 : sat_exp[b-1]);
        step(0, 1, 4'b1111);
        check($sformatf("brk%0d", b), 4, 1, 0, 1, 0, sat_exp[b]);
      end
    end

    // Random traffic biased toward the expected successor so locks occur.
    step(1, 1, 4'b0000);
    check("rnd_rst", 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 600; t++) begin
      logic r, e;
      logic [N-1:0] c;
      int p;
      r = ($urandom_range(0, 79) == 0);
      e = ($urandom_range(0, 3) != 0);
      p = $urandom_range(0, 99);
      if (p < 75)      c = jt[(m_idx + 1) % M];
      else if (p < 88) c = jt[$urandom_range(0, M-1)];
      else             c = N'($urandom_range(0, (1 << N) - 1));
      step(r, e, c);
      check($sformatf("rnd%0d", t), m_idx, e_valid, e_illegal, e_seq, (m_mode == 2), m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/johnson_4_decoder.md
# johnson_4_decoder

Receive-side companion to the synchronous Johnson counter. Samples an N-bit Johnson code, decodes it to a binary step index, and checks every qualified sample against the expected successor. A HUNT/ACQ/LOCK state machine reports lock status, flags illegal codes and sequence breaks, and keeps a saturating error count. It sits downstream of a Johnson counter, or of any bus carrying Johnson-coded state, as a decoder and monitor.

## Interface
- N, 4, Johnson register width; the sequence has 2N states
- LOCK_LEN, 2, consecutive correct successor samples needed after first capture before lock is declared (≥1)
- ERR_W, 8, error counter width
- IW, $clog2(2N), index width (derived, not overridable)

- clk  in  1  clock; all logic updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample qualifier; q is evaluated only on cycles where en=1
- q  in  N  Johnson code under test
- idx  out  IW  decoded step index of the last legal sample
- valid  out  1  one-cycle pulse: the last sample was legal
- illegal  out  1  one-cycle pulse: the last sample was not a Johnson code
- seq_err  out  1  one-cycle pulse: sequence break while in LOCK
- locked  out  1  high while the FSM is in LOCK
- err_cnt  out  ERR_W  saturating count of seq_err events

## Operation
- Legality: q is legal iff (q[N-1:1] ^ q[N-2:0]) has at most one bit set. This gives exactly 2N codes: 0000,0001,0011,0111,1111,1110,1100,1000 for N=4.
- Decode: if q[N-1]=0, index = popcount(q); otherwise index = 2N − popcount(q). Examples: 0000→0, 0111→3, 1111→4, 1000→7.
- Expected successor = (prev index + 1) mod 2N. The wrap from 2N−1 to 0 (1000→0000) is a correct step.
- HUNT:
  - legal sample → capture index, run=0, go to ACQ.
  - illegal sample → pulse illegal, stay in HUNT.
- ACQ:
  - correct successor → run++. When run reaches LOCK_LEN, go to LOCK.
  - legal but wrong sample → recapture index, run=0, stay in ACQ.
  - illegal sample → pulse illegal, go to HUNT.
  - No seq_err is raised in ACQ.
- LOCK:
  - correct successor → stay in LOCK.
  - legal but wrong sample (including a repeat of the same code) → pulse seq_err, err_cnt++, recapture index, run=0, go to ACQ.
  - illegal sample → pulse illegal and seq_err, err_cnt++, go to HUNT.
- idx updates on every legal sample and holds on illegal samples.
- valid pulses on every legal sample, in any state.
- err_cnt saturates at 2^ERR_W−1 and never wraps.
- en=0: no state change, idx, locked and err_cnt hold, all pulse outputs are 0.

## Timing
- All outputs are registered. For a sample taken at edge k, its results appear after edge k and are valid for one cycle. Latency is 1 cycle.
- locked rises in the cycle after the LOCK_LEN-th correct successor is sampled. It falls in the cycle after the breaking sample.
- Reset values: idx=0, valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0, state=HUNT, run=0.
- rst has priority over en. Reset mid-lock clears everything on that edge, including err_cnt.
- An illegal sample in LOCK asserts illegal and seq_err in the same cycle.

## Configuration
- JOHNSON_DEC_ERRCNT_EN:
  - defined: err_cnt is implemented as described above.
  - undefined: the counter register is omitted and err_cnt is tied to 0. The seq_err pulse and all FSM behaviour are unchanged.

## Test plan
- Reset, then en=1 with q stepping 0000,0001,0011: valid each cycle, idx=0,1,2; locked=1 the cycle after the 0011 sample; illegal=0, seq_err=0.
- Locked, q continues 0111,1111,1110,1100,1000,0000: idx runs 3..7 then 0; locked stays 1, seq_err=0 (wrap accepted).
- Locked at idx=2, then q=0101: illegal=1, seq_err=1, err_cnt=1, locked=0; FSM returns to HUNT, idx stays 2.
- Locked at idx=2, then q=1111 (skip): seq_err=1, illegal=0, idx=4, locked=0; then 1110,1100 → locked=1 again.
- ERR_W=2: cause 5 sequence breaks, relocking between each → err_cnt=1,2,3,3,3.
- Locked, en held 0 for 3 cycles with q=0101: no pulses, locked=1, idx unchanged. Then assert rst with en=1 → all outputs 0 on the next cycle.
